// File: rtl/count_uart_tx_pkg.sv
// Shared constants, FSM state type and hex-to-ASCII helper for the count UART transmitter.
package count_uart_pkg;

    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam int         NUM_CHARS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Uppercase hex: 0x37 + 10 = 0x41 ('A').
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] i_nib);
        if (i_nib < 4'd10) begin
            return 8'h30 + {4'h0, i_nib};
        end
        return 8'h37 + {4'h0, i_nib};
    endfunction

endpackage

// File: rtl/count_uart_tx_if.sv
// Valid/ready capture port carrying the 8-bit count value into the transmitter.
interface count_uart_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/count_uart_tx_byte.sv
// Single 8N1 frame serializer; accepts the next byte on the last stop-bit edge so frames chain gaplessly.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_byte_in,
    input  logic       i_byte_valid,
    output logic       o_byte_ready,
    output logic       o_tx,
    output logic       o_frame_done
);
    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  BAUD_ONE  = BW'(1);
    localparam logic [3:0]     STOP_IDX  = 4'd9;

    logic          r_active;
    logic [BW-1:0] r_baud;
    logic [3:0]    r_bit_idx;
    logic [7:0]    r_byte;
    logic          r_tx;
    logic          w_bit_end;
    logic          w_last;

    assign w_bit_end    = r_active && (r_baud == BAUD_LAST);
    assign w_last       = w_bit_end && (r_bit_idx == STOP_IDX);
    assign o_frame_done = w_last;
    assign o_byte_ready = !r_active || w_last;
    assign o_tx         = r_tx;

    // Bit index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active  <= 1'b0;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_byte    <= '0;
            r_tx      <= 1'b1;
        end else if (o_byte_ready && i_byte_valid) begin
            r_active  <= 1'b1;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_byte    <= i_byte_in;
            r_tx      <= 1'b0;
        end else if (w_last) begin
            r_active  <= 1'b0;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= r_bit_idx + 4'd1;
            r_tx      <= (r_bit_idx == 4'd8) ? 1'b1 : r_byte[r_bit_idx[2:0]];
        end else if (r_active) begin
            r_baud    <= r_baud + BAUD_ONE;
        end
    end
endmodule

// File: rtl/count_uart_tx.sv
// Captures one count value and sends it as "HL\r\n" (uppercase hex) over a UART TX line.
// state | meaning
// IDLE  | line idle high, ready to capture a count value
// SEND  | four frames in flight; r_char_idx is the char currently on the line
module count_uart_tx
    import count_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic          i_clk,
    input  logic          i_rst,
    count_uart_tx_if.slave bus,
    output logic          o_tx,
    output logic          o_busy
);
    localparam logic [1:0] LAST_IDX = 2'(NUM_CHARS - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_char_idx;
    logic [1:0] w_char_idx_next;
    logic [7:0] r_data;
    logic       w_capture;
    logic       w_byte_valid;
    logic       w_byte_ready;
    logic       w_frame_done;
    logic       w_in_ready;
    logic [1:0] w_sel_idx;
    logic [7:0] w_src;
    logic [7:0] w_char;

    assign w_capture   = (r_state == IDLE) && bus.in_valid && w_byte_ready;
    assign bus.in_ready = w_in_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_char_idx <= '0;
            r_data     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_char_idx <= w_char_idx_next;
            if (w_capture) begin
                r_data <= bus.in_data;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_char_idx_next = r_char_idx;
        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_state_next    = SEND;
                    w_char_idx_next = '0;
                end
            end
            SEND: begin
                if (w_frame_done) begin
                    if (r_char_idx == LAST_IDX) begin
                        w_state_next    = IDLE;
                        w_char_idx_next = '0;
                    end else begin
                        w_char_idx_next = r_char_idx + 2'd1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The serializer loads on the edge that ends the current frame, so offer the following char.
    always_comb begin
        w_in_ready   = (r_state == IDLE);
        o_busy       = (r_state == SEND);
        w_sel_idx    = (r_state == IDLE) ? 2'd0 : (r_char_idx + 2'd1);
        w_src        = (r_state == IDLE) ? bus.in_data : r_data;
        w_byte_valid = w_capture || ((r_state == SEND) && (r_char_idx != LAST_IDX));
        case (w_sel_idx)
            2'd0:    w_char = hex_to_ascii(w_src[7:4]);
            2'd1:    w_char = hex_to_ascii(w_src[3:0]);
            2'd2:    w_char = CHAR_CR;
            default: w_char = CHAR_LF;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_byte_in    (w_char),
        .i_byte_valid (w_byte_valid),
        .o_byte_ready (w_byte_ready),
        .o_tx         (o_tx),
        .o_frame_done (w_frame_done)
    );
endmodule

// File: doc/count_uart_tx.md
# count_uart_tx

Downstream consumer of the 8-bit counter output. It captures one 8-bit count value through a valid/ready handshake. It then transmits the value on a single UART TX pin as four 8N1 frames: the ASCII uppercase hex high nibble, the hex low nibble, CR (0x0D) and LF (0x0A). It drives a dedicated output pin of the tile so a host terminal can log counter values.

## Interface
- CLKS_PER_BIT, default 87, clock cycles per UART bit (10 MHz / 115200); legal range ≥ 2.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  8  count value; sampled only on the capture edge.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  block is idle and will capture on this edge if in_valid=1; registered.
- tx  output  1  UART serial line, idle high; registered.
- busy  output  1  message in progress; registered.

## Operation
- One clock domain; reset is synchronous and active-high.
- Reset values, applied on the first edge with rst=1:
  - tx=1, in_ready=1, busy=0.
  - Char index, bit index and baud counter are 0.
- Capture happens on an edge where in_valid=1 and in_ready=1.
  - in_data is latched into a holding register.
  - The same edge drives in_ready←0, busy←1 and tx←0 (start bit of char 0).
- Char sequence: hex(in_data[7:4]), hex(in_data[3:0]), 0x0D, 0x0A.
- Hex mapping: n in 0–9 maps to 0x30+n; n in 10–15 maps to 0x41+(n−10). Output is uppercase.
- Frame format: start bit 0, data bits LSB first, stop bit 1. No parity. Each bit is held exactly CLKS_PER_BIT cycles.
- Frames are back-to-back. The start bit of char k+1 follows the last stop-bit cycle of char k, with no idle gap.
- While busy:
  - in_valid and in_data are ignored.
  - There is no buffering; an offer made while busy is lost.
- Message end: the edge that ends the LF stop bit drives tx=1 (stays 1), in_ready←1 and busy←0.
- Reset mid-message: on the next edge tx=1, in_ready=1 and busy=0. The partial frame is abandoned and nothing resumes.
- Simultaneous rst=1 and in_valid=1: reset wins and no capture happens.
- Baud counter width: $clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT−1 and advances the bit index.

## Timing
- Capture edge E0. Bit j of the message, j = 0..39, is on tx during cycles [E0 + j·C, E0 + (j+1)·C), where C = CLKS_PER_BIT.
- Message end edge: E0 + 40·C, where in_ready=1 and busy=0.
- Earliest next capture: E0 + 40·C + 1. The line therefore idles high for at least 1 cycle between messages.
- Latency from capture to the first tx transition: 0 cycles, because tx falls on the capture edge itself.
- in_ready deasserts on the capture edge. An upstream holding in_valid high sees exactly one capture per message.

## Structure
- Package count_uart_pkg:
  - Constants CHAR_CR=8'h0D and CHAR_LF=8'h0A.
  - Function hex_to_ascii(4-bit) returning 8 bits.
  - Message length constant NUM_CHARS=4.
  - Enum for the outer FSM states IDLE and SEND.
- Sub-module uart_tx_byte (parameter CLKS_PER_BIT), a single-frame serializer with these ports:
  - byte_in[7:0], byte_valid, byte_ready.
  - tx.
  - frame_done (1-cycle pulse on the last stop-bit cycle).
- uart_tx_byte must accept the next byte on that last stop-bit edge so frames stay gapless.
- Top FSM:
  - Holds the captured value and a 2-bit char index.
  - Selects the char with a mux over hex_to_ascii, CR and LF.
  - Returns to IDLE on the frame_done of char 3.

## Test plan
All scenarios run with CLKS_PER_BIT=4.
- Reset: assert rst for 2 cycles mid-idle → tx=1, in_ready=1, busy=0; tx is stable for 20 further cycles with no activity.
- Send 0x3A → chars 0x33, 0x41, 0x0D, 0x0A.
  - Char 0x33 on the line: 0,1,1,0,0,1,1,0,0,1, each bit 4 cycles.
  - busy=1 for exactly 160 cycles; in_ready=1 at E0+160.
- Nibble boundaries: 0x00 → "00", 0xFF → "FF", 0x09 → "09", 0x0A → "0A", each followed by CR LF.
- Streaming: hold in_valid=1 while in_data increments every cycle.
  - Each message carries the value present at its capture edge.
  - Successive captures are 161 cycles apart; tx is high for exactly 1 cycle between messages.
- Offer while busy: pulse in_valid with 0x55 at E0+50 → ignored; only the original message is sent and no second message follows.
- Reset mid-message: assert rst during the data bits of char 1 → tx=1 on the next edge and in_ready=1. A new capture of 0xC3 then yields a clean "C3\r\n".
